dog_line_scheduler: RTL and testbench
=====================================

Name: dog_line_scheduler

Overview:
- Per-scanline sprite scheduler for the dog battle VGA pipeline.
- Each horizontal blanking interval, it walks the N dogs through a shared game-state read port and tests each one against the next scanline.
- It builds a list of up to SLOTS dog bodies and hit bars that touch that line, then commits the list in one cycle.
- The pixel compositor then needs only SLOTS horizontal comparators per pixel instead of N box-plus-bar tests.

Parameters:
- N, 8, number of dogs scanned; legal range 1..8.
- SLOTS, 4, maximum drawable entries per line; legal range 1..8.
- BOX_H, 32, dog box height in lines.

Ports:
- pix_clk  in  1  pixel clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- line_start  in  1  one-cycle pulse at hblank start; begins a scan.
- next_y  in  9  line to schedule for; sampled on line_start.
- fetch_req  out  1  read request to the game-state port.
- fetch_idx  out  3  dog index requested.
- fetch_ack  in  1  data valid; honoured only while fetch_req=1; may rise in the same cycle as fetch_req.
- fetch_posx  in  10  dog x position, valid with ack.
- fetch_posy  in  9  dog y position, valid with ack.
- fetch_col  in  3  dog colour index, valid with ack.
- fetch_hits  in  8  dog hit count, valid with ack.
- slot_x  out  SLOTS*10  committed x per slot; slot k is bits [10k+9:10k].
- slot_col  out  SLOTS*3  committed colour per slot.
- slot_bar  out  SLOTS  1 = entry is a hit bar, 0 = entry is a body.
- slot_valid  out  SLOTS  committed slot occupied.
- line_ready  out  1  one-cycle pulse on commit.
- overflow  out  1  committed line had more than SLOTS candidates.
- late  out  1  one-cycle pulse when a scan was aborted.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous on rst_n low:
  - State goes to IDLE.
  - All outputs go to 0: slot_x, slot_col, slot_bar, slot_valid, line_ready, overflow, late, busy, fetch_req, fetch_idx.
  - Shadow list, shadow count and the captured next_y register clear.
  - A reset during a scan discards that scan.
- State machine, states IDLE, REQ, EVAL, DONE:
  - IDLE, with line_start: latch next_y as ny, clear the shadow list, set idx=0, go to REQ.
  - REQ: fetch_req=1 and fetch_idx=idx. On fetch_ack, capture posx/posy/col/hits and go to EVAL; otherwise hold.
  - EVAL: run the hit test and append to the shadow list. If idx==N-1, go to DONE; else idx+=1 and go to REQ.
  - DONE: commit the shadow list to the slot_* outputs and overflow in one cycle, pulse line_ready, go to IDLE.
- Latency:
  - With zero-wait ack, line_ready is high exactly 2N+2 cycles after the line_start cycle (18 for N=8).
  - This fits inside the 160-cycle hblank.
- Hit test arithmetic, all comparisons unsigned and 10 bits wide:
  - hh = floor(hits*BOX_H/255), computed at 14-bit precision.
  - Body condition: ny >= posy and ny < posy+BOX_H.
  - Bar condition: hh != 0 and ny < posy and ny+hh >= posy. This is done without subtraction, so there is no underflow when posy < hh.
  - Body and bar are mutually exclusive for one dog; each dog yields at most one entry.
  - posy+BOX_H above 479 is not clipped; the compositor ignores lines past 479.
- List order and capacity:
  - Entries are appended in ascending dog index. The compositor paints ascending slots so that higher dog indices win, and bar entries override bodies.
  - Once SLOTS entries exist, further candidates are dropped and the shadow overflow bit is set.
  - Committed overflow reflects only the committed line.
- Commit:
  - Unused slots get slot_valid=0; slot_x/col/bar for those slots go to 0.
  - The committed list holds until the next DONE.
- line_start while busy (REQ, EVAL or DONE-entry cycle):
  - Abort, discard the shadow list, pulse late, latch the new next_y, restart at idx 0 in REQ.
  - Committed outputs are unchanged.
  - line_start in the same cycle as DONE: the commit completes, then the restart applies (late not pulsed).
- fetch_ack while fetch_req=0 is ignored.

Test Plan:
- Reset mid-scan: assert rst_n=0 while in EVAL -> all outputs 0 and busy=0 immediately; no line_ready follows.
- Body test: dog0 posy=100, posx=200, col=5; other dogs posy=400 hits=0; next_y=115; zero-wait ack -> line_ready 18 cycles after line_start; slot0 x=200, col=5, bar=0, valid=0001, overflow=0.
- Bar test: dog2 posy=100, hits=128 (hh=16); next_y=84 -> slot0 bar=1. Same with next_y=83 -> valid=0000. Same with hits=7 (hh=0) and next_y=99 -> valid=0000.
- Overflow: six dogs at posy=50; next_y=60; SLOTS=4 -> slots hold dogs 0,1,2,3 in order; valid=1111; overflow=1. Next line with none overlapping -> overflow=0, valid=0000.
- Wait states and underflow: ack delayed 3 cycles per fetch -> same result, line_ready at 2N+2+3N cycles. Dog posy=5, hits=255 (hh=32), next_y=0 -> bar entry, no wrap.
- Abort: second line_start 5 cycles after the first, with next_y=200 -> late pulses once; committed list is unchanged until line_ready, which arrives 18 cycles after the second pulse and reflects y=200.

Source files
------------

// File: rtl/dog_line_scheduler_if.sv
// Game-state fetch port and the committed per-scanline slot list of the dog line scheduler.
interface dog_line_scheduler_if #(parameter int SLOTS = 4);
  logic                line_start;
  logic [8:0]          next_y;
  logic                fetch_req;
  logic [2:0]          fetch_idx;
  logic                fetch_ack;
  logic [9:0]          fetch_posx;
  logic [8:0]          fetch_posy;
  logic [2:0]          fetch_col;
  logic [7:0]          fetch_hits;
  logic [SLOTS*10-1:0] slot_x;
  logic [SLOTS*3-1:0]  slot_col;
  logic [SLOTS-1:0]    slot_bar;
  logic [SLOTS-1:0]    slot_valid;
  logic                line_ready;
  logic                overflow;
  logic                late;
  logic                busy;

  modport master (
    input  line_start, next_y, fetch_ack, fetch_posx, fetch_posy, fetch_col, fetch_hits,
    output fetch_req, fetch_idx, slot_x, slot_col, slot_bar, slot_valid,
           line_ready, overflow, late, busy
  );

  modport slave (
    output line_start, next_y, fetch_ack, fetch_posx, fetch_posy, fetch_col, fetch_hits,
    input  fetch_req, fetch_idx, slot_x, slot_col, slot_bar, slot_valid,
           line_ready, overflow, late, busy
  );
endinterface

// File: rtl/dog_line_scheduler.sv
// Per-scanline sprite scheduler: walks N dogs during hblank and commits up to SLOTS
// body/hit-bar entries touching the next line for the pixel compositor.
module dog_slot_reg (
  input  logic       pix_clk,
  input  logic       rst_n,
  input  logic       commit,
  input  logic       vld_d,
  input  logic [9:0] x_d,
  input  logic [2:0] col_d,
  input  logic       bar_d,
  output logic       vld_q,
  output logic [9:0] x_q,
  output logic [2:0] col_q,
  output logic       bar_q
);
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      x_q   <= '0;
      col_q <= '0;
      bar_q <= 1'b0;
    end else if (commit) begin
      vld_q <= vld_d;
      x_q   <= vld_d ? x_d   : '0;
      col_q <= vld_d ? col_d : '0;
      bar_q <= vld_d & bar_d;
    end
  end
endmodule

module dog_line_scheduler #(
  parameter int N     = 8,
  parameter int SLOTS = 4,
  parameter int BOX_H = 32
) (
  input logic                   pix_clk,
  input logic                   rst_n,
  dog_line_scheduler_if.master  bus
);
  typedef enum logic [1:0] {IDLE, REQ, EVAL, DONE} state_t;
  localparam logic [2:0] LAST = 3'(N - 1);

  state_t state, state_nxt;

  logic [8:0] ny;
  logic [2:0] idx;
  logic [9:0] c_posx;
  logic [8:0] c_posy;
  logic [2:0] c_col;
  logic [7:0] c_hits;

  logic [SLOTS-1:0][9:0] sh_x;
  logic [SLOTS-1:0][2:0] sh_col;
  logic [SLOTS-1:0]      sh_bar;
  logic [3:0]            sh_cnt;
  logic                  sh_ovf;

  logic late_q, ready_q, ovf_q;

  // Hit test, all in 10-bit unsigned; the bar test adds hh to ny instead of
  // subtracting it from posy so a dog near the top of the screen cannot wrap.
  logic [13:0] prod;
  logic [9:0]  hh, ny_w, py_w;
  logic        body_hit, bar_hit, cand;

  always_comb begin
    prod     = 14'(c_hits) * 14'(BOX_H);
    hh       = 10'(prod / 14'd255);
    ny_w     = {1'b0, ny};
    py_w     = {1'b0, c_posy};
    body_hit = (ny_w >= py_w) && (ny_w < py_w + 10'(BOX_H));
    bar_hit  = (hh != 10'd0) && (ny_w < py_w) && (ny_w + hh >= py_w);
    cand     = body_hit || bar_hit;
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.line_start) state_nxt = REQ;
      REQ:  if (bus.line_start) state_nxt = REQ;
            else if (bus.fetch_ack) state_nxt = EVAL;
      EVAL: if (bus.line_start) state_nxt = REQ;
            else if (idx == LAST) state_nxt = DONE;
            else state_nxt = REQ;
      DONE: state_nxt = bus.line_start ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.fetch_req = (state == REQ);
    bus.fetch_idx = (state == REQ) ? idx : 3'd0;
    bus.busy      = (state != IDLE);
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      ny      <= '0;
      idx     <= '0;
      c_posx  <= '0;
      c_posy  <= '0;
      c_col   <= '0;
      c_hits  <= '0;
      sh_x    <= '0;
      sh_col  <= '0;
      sh_bar  <= '0;
      sh_cnt  <= '0;
      sh_ovf  <= 1'b0;
      late_q  <= 1'b0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      late_q  <= bus.line_start && (state == REQ || state == EVAL);
      ready_q <= (state == DONE);
      if (state == DONE) ovf_q <= sh_ovf;
      // A line_start in any state (re)starts the scan; in DONE the commit still uses the old list.
      if (bus.line_start) begin
        ny     <= bus.next_y;
        idx    <= '0;
        sh_x   <= '0;
        sh_col <= '0;
        sh_bar <= '0;
        sh_cnt <= '0;
        sh_ovf <= 1'b0;
      end else if (state == REQ && bus.fetch_ack) begin
        c_posx <= bus.fetch_posx;
        c_posy <= bus.fetch_posy;
        c_col  <= bus.fetch_col;
        c_hits <= bus.fetch_hits;
      end else if (state == EVAL) begin
        if (idx != LAST) idx <= idx + 3'd1;
        if (cand) begin
          if (sh_cnt < 4'(SLOTS)) begin
            for (int k = 0; k < SLOTS; k++) begin
              if (sh_cnt == 4'(k)) begin
                sh_x[k]   <= c_posx;
                sh_col[k] <= c_col;
                sh_bar[k] <= bar_hit;
              end
            end
            sh_cnt <= sh_cnt + 4'd1;
          end else begin
            sh_ovf <= 1'b1;
          end
        end
      end
    end
  end

  logic [SLOTS-1:0][9:0] sx_q;
  logic [SLOTS-1:0][2:0] scol_q;
  logic [SLOTS-1:0]      sbar_q, svld_q;

  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    dog_slot_reg u_slot (
      .pix_clk (pix_clk),
      .rst_n   (rst_n),
      .commit  (state == DONE),
      .vld_d   (sh_cnt > 4'(k)),
      .x_d     (sh_x[k]),
      .col_d   (sh_col[k]),
      .bar_d   (sh_bar[k]),
      .vld_q   (svld_q[k]),
      .x_q     (sx_q[k]),
      .col_q   (scol_q[k]),
      .bar_q   (sbar_q[k])
    );
  end

  assign bus.slot_x     = sx_q;
  assign bus.slot_col   = scol_q;
  assign bus.slot_bar   = sbar_q;
  assign bus.slot_valid = svld_q;
  assign bus.line_ready = ready_q;
  assign bus.overflow   = ovf_q;
  assign bus.late       = late_q;
endmodule

// File: tb/tb_dog_line_scheduler.sv
// Directed bench for dog_line_scheduler: a driver pushes hand-computed line lists,
// a monitor pops and compares them on every line_ready pulse.
module tb_dog_line_scheduler;
  localparam int N = 8, SLOTS = 4, BOX_H = 32;

  logic pix_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 pix_clk = ~pix_clk;

  dog_line_scheduler_if #(.SLOTS(SLOTS)) bus();

  dog_line_scheduler #(.N(N), .SLOTS(SLOTS), .BOX_H(BOX_H)) dut (
    .pix_clk (pix_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [39:0] x;
    logic [11:0] col;
    logic [3:0]  bar;
    logic [3:0]  vld;
    logic        ovf;
    int          ecyc;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0, cyc = 0, ack_dly = 0, wcnt = 0, rdy_cnt = 0, late_cnt = 0;

  logic [9:0] d_posx [N];
  logic [8:0] d_posy [N];
  logic [2:0] d_col  [N];
  logic [7:0] d_hits [N];

  // Game-state port model: ack after ack_dly stalled request cycles.
  assign bus.fetch_ack  = bus.fetch_req && (wcnt >= ack_dly);
  assign bus.fetch_posx = d_posx[bus.fetch_idx];
  assign bus.fetch_posy = d_posy[bus.fetch_idx];
  assign bus.fetch_col  = d_col[bus.fetch_idx];
  assign bus.fetch_hits = d_hits[bus.fetch_idx];

  initial forever begin
    @(posedge pix_clk);
    cyc++;
  end

  initial forever begin
    @(posedge pix_clk);
    if (bus.fetch_req && !bus.fetch_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor / scoreboard
  initial forever begin
    @(negedge pix_clk);
    if (bus.late) late_cnt++;
    if (rst_n && bus.line_ready) begin
      rdy_cnt++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_line_ready: got pulse at cycle %0d want none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("slot_x",     bus.slot_x,     e.x);
        check("slot_col",   bus.slot_col,   e.col);
        check("slot_bar",   bus.slot_bar,   e.bar);
        check("slot_valid", bus.slot_valid, e.vld);
        check("overflow",   bus.overflow,   e.ovf);
        check("ready_cycle", cyc, e.ecyc);
      end
    end
  end

  function automatic exp_t one(input logic [9:0] x, input logic [2:0] c, input logic b);
    exp_t e;
    e = '{default: '0};
    e.x[9:0]  = x;
    e.col[2:0] = c;
    e.bar[0]  = b;
    e.vld     = 4'b0001;
    return e;
  endfunction

  function automatic exp_t none();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  task automatic dogs_default();
    for (int i = 0; i < N; i++) begin
      d_posx[i] = '0;
      d_posy[i] = 9'd400;
      d_col[i]  = '0;
      d_hits[i] = '0;
    end
  endtask

  task automatic issue(input logic [8:0] y, input exp_t e, input int lat, input bit push);
    @(negedge pix_clk);
    if (push) begin
      e.ecyc = cyc + lat;
      q.push_back(e);
    end
    bus.next_y     = y;
    bus.line_start = 1'b1;
    @(negedge pix_clk);
    bus.line_start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge pix_clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got %0d pending want 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge pix_clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_slot_x"},     bus.slot_x,     '0);
    check({tag, "_slot_col"},   bus.slot_col,   '0);
    check({tag, "_slot_bar"},   bus.slot_bar,   '0);
    check({tag, "_slot_valid"}, bus.slot_valid, '0);
    check({tag, "_line_ready"}, bus.line_ready, '0);
    check({tag, "_overflow"},   bus.overflow,   '0);
    check({tag, "_late"},       bus.late,       '0);
    check({tag, "_busy"},       bus.busy,       '0);
    check({tag, "_fetch_req"},  bus.fetch_req,  '0);
    check({tag, "_fetch_idx"},  bus.fetch_idx,  '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int late0, rc;
    bus.line_start = 1'b0;
    bus.next_y     = '0;
    dogs_default();
    #12;
    check_zero("reset");
    repeat (2) @(negedge pix_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge pix_clk);

    // Body entry, zero-wait
    d_posy[0] = 9'd100; d_posx[0] = 10'd200; d_col[0] = 3'd5;
    issue(9'd115, one(10'd200, 3'd5, 1'b0), 18, 1'b1);
    drain();

    // Hit bar: hits=128 -> hh=16
    dogs_default();
    d_posy[2] = 9'd100; d_hits[2] = 8'd128; d_posx[2] = 10'd300; d_col[2] = 3'd2;
    issue(9'd84, one(10'd300, 3'd2, 1'b1), 18, 1'b1);
    drain();
    issue(9'd83, none(), 18, 1'b1);
    drain();
    d_hits[2] = 8'd7;
    issue(9'd99, none(), 18, 1'b1);
    drain();

    // Overflow: six candidates, four slots
    dogs_default();
    for (int i = 0; i < 6; i++) begin
      d_posy[i] = 9'd50;
      d_posx[i] = 10'(10 * (i + 1));
      d_col[i]  = 3'(i);
    end
    e = none();
    e.x   = {10'd40, 10'd30, 10'd20, 10'd10};
    e.col = {3'd3, 3'd2, 3'd1, 3'd0};
    e.vld = 4'b1111;
    e.ovf = 1'b1;
    issue(9'd60, e, 18, 1'b1);
    drain();
    issue(9'd300, none(), 18, 1'b1);
    drain();

    // Wait states: three stall cycles per fetch
    dogs_default();
    ack_dly = 3;
    d_posy[0] = 9'd100; d_posx[0] = 10'd200; d_col[0] = 3'd5;
    issue(9'd115, one(10'd200, 3'd5, 1'b0), 2*N + 2 + 3*N, 1'b1);
    drain();
    ack_dly = 0;

    // Bar near the top of the screen: posy=5, hh=32, ny=0
    dogs_default();
    d_posy[3] = 9'd5; d_hits[3] = 8'd255; d_posx[3] = 10'd77; d_col[3] = 3'd6;
    issue(9'd0, one(10'd77, 3'd6, 1'b1), 18, 1'b1);
    drain();

    // Abort: restart 5 cycles into a scan
    dogs_default();
    d_posy[1] = 9'd190; d_posx[1] = 10'd111; d_col[1] = 3'd4;
    late0 = late_cnt;
    issue(9'd0, none(), 0, 1'b0);
    repeat (3) @(negedge pix_clk);
    issue(9'd200, one(10'd111, 3'd4, 1'b0), 18, 1'b1);
    repeat (3) @(negedge pix_clk);
    check("abort_hold_slot_x",     bus.slot_x,     40'd77);
    check("abort_hold_slot_bar",   bus.slot_bar,   4'b0001);
    check("abort_hold_slot_valid", bus.slot_valid, 4'b0001);
    drain();
    check("late_pulses", late_cnt - late0, 1);

    // Reset while in EVAL
    @(negedge pix_clk);
    bus.next_y = 9'd195; bus.line_start = 1'b1;
    @(negedge pix_clk);
    bus.line_start = 1'b0;
    @(negedge pix_clk);
    check("pre_reset_busy", bus.busy, 1'b1);
    check("pre_reset_fetch_req", bus.fetch_req, 1'b0);
    rc = rdy_cnt;
    rst_n = 1'b0;
    #1;
    check_zero("midscan_reset");
    repeat (2) @(negedge pix_clk);
    rst_n = 1'b1;
    repeat (30) @(negedge pix_clk);
    check("no_ready_after_reset", rdy_cnt, rc);
    check("idle_after_reset", bus.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
